// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA raster timing generator with a pixel clock-enable and registered decode.
// Latency: one clock from the pre-advance (hc, vc) position to sync, enable, coordinate and tik outputs.
// Backpressure: none; pix_en=0 holds counters and level outputs, and forces all tiks low.
module vga_timing_gen #(
  parameter int   H_DISPLAY     = 640,
  parameter int   H_FRONT_PORCH = 16,
  parameter int   H_SYNC_PULSE  = 96,
  parameter int   H_BACK_PORCH  = 48,
  parameter int   V_DISPLAY     = 480,
  parameter int   V_FRONT_PORCH = 10,
  parameter int   V_SYNC_PULSE  = 2,
  parameter int   V_BACK_PORCH  = 33,
  parameter logic H_SYNC_POL    = 1'b0,
  parameter logic V_SYNC_POL    = 1'b0,
  parameter int   COORD_BIT     = 10,
  parameter int   FRAME_BIT     = 8
) (
  input  logic                 clock_25,
  input  logic                 reset,
  input  logic                 pix_en,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 display_area,
  output logic [COORD_BIT-1:0] X,
  output logic [COORD_BIT-1:0] Y,
  output logic                 line_tik,
  output logic                 frame_tik,
  output logic                 vblank_tik,
  output logic [FRAME_BIT-1:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  // Boundaries sized to the counter width so every compare is width-matched.
  localparam logic [COORD_BIT-1:0] H_LAST   = COORD_BIT'(H_TOTAL - 1);
  localparam logic [COORD_BIT-1:0] V_LAST   = COORD_BIT'(V_TOTAL - 1);
  localparam logic [COORD_BIT-1:0] H_ACT    = COORD_BIT'(H_DISPLAY);
  localparam logic [COORD_BIT-1:0] V_ACT    = COORD_BIT'(V_DISPLAY);
  localparam logic [COORD_BIT-1:0] HS_START = COORD_BIT'(H_DISPLAY + H_FRONT_PORCH);
  localparam logic [COORD_BIT-1:0] HS_END   = COORD_BIT'(H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [COORD_BIT-1:0] VS_START = COORD_BIT'(V_DISPLAY + V_FRONT_PORCH);
  localparam logic [COORD_BIT-1:0] VS_END   = COORD_BIT'(V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE);

  // Raster position and completed-frame count.
  logic [COORD_BIT-1:0] hc_q, hc_d;
  logic [COORD_BIT-1:0] vc_q, vc_d;
  logic [FRAME_BIT-1:0] fc_q, fc_d;

  // Decoded view of the current (pre-advance) position.
  logic                 hs_d, vs_d, de_d, lt_d, ft_d, vt_d;
  logic [COORD_BIT-1:0] x_d, y_d;

  // Registered outputs.
  logic                 hs_q, vs_q, de_q, lt_q, ft_q, vt_q;
  logic [COORD_BIT-1:0] x_q, y_q;
  logic [FRAME_BIT-1:0] fco_q;

  // Next raster position: advance only on pixel-enable, wrap line then frame.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    fc_d = fc_q;
    if (pix_en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        if (vc_q == V_LAST) begin
          vc_d = '0;
          fc_d = fc_q + 1'b1;
        end else begin
          vc_d = vc_q + 1'b1;
        end
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // Decode sync, active area and tiks from the position before it advances.
  always_comb begin
    de_d = (hc_q < H_ACT) && (vc_q < V_ACT);
    x_d  = de_d ? hc_q : '0;
    y_d  = de_d ? vc_q : '0;
    hs_d = ((hc_q >= HS_START) && (hc_q < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vs_d = ((vc_q >= VS_START) && (vc_q < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    lt_d = (hc_q == '0);
    ft_d = (hc_q == '0) && (vc_q == '0);
    vt_d = (hc_q == '0) && (vc_q == V_ACT);
  end

  // State and output registers; reset wins over pix_en, tiks never outlive one clock.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      hc_q  <= '0;
      vc_q  <= '0;
      fc_q  <= '0;
      hs_q  <= ~H_SYNC_POL;
      vs_q  <= ~V_SYNC_POL;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      lt_q  <= 1'b0;
      ft_q  <= 1'b0;
      vt_q  <= 1'b0;
      fco_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      fc_q <= fc_d;
      if (pix_en) begin
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        de_q  <= de_d;
        x_q   <= x_d;
        y_q   <= y_d;
        lt_q  <= lt_d;
        ft_q  <= ft_d;
        vt_q  <= vt_d;
        fco_q <= fc_q;
      end else begin
        lt_q <= 1'b0;
        ft_q <= 1'b0;
        vt_q <= 1'b0;
      end
    end
  end

  assign h_sync       = hs_q;
  assign v_sync       = vs_q;
  assign display_area = de_q;
  assign X            = x_q;
  assign Y            = y_q;
  assign line_tik     = lt_q;
  assign frame_tik    = ft_q;
  assign vblank_tik   = vt_q;
  assign frame_count  = fco_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: scoreboard bench for vga_timing_gen, default 640x480 timing plus a tiny positive-polarity raster.
// Latency: expected outputs are queued at each clock edge and compared on the following falling edge.
// Backpressure: none; pix_en and reset are randomised, including mid-line resets.
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  logic en;

  // Default-parameter instance.
  logic       hs_a, vs_a, de_a, lt_a, ft_a, vt_a;
  logic [9:0] x_a, y_a;
  logic [7:0] fc_a;

  // Small raster: H 8/2/2/2, V 4/1/1/1, positive syncs, 2-bit frame counter.
  logic       hs_b, vs_b, de_b, lt_b, ft_b, vt_b;
  logic [3:0] x_b, y_b;
  logic [1:0] fc_b;

  vga_timing_gen dut_a (
    .clock_25(clk), .reset(rst), .pix_en(en),
    .h_sync(hs_a), .v_sync(vs_a), .display_area(de_a), .X(x_a), .Y(y_a),
    .line_tik(lt_a), .frame_tik(ft_a), .vblank_tik(vt_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(2), .H_BACK_PORCH(2),
    .V_DISPLAY(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COORD_BIT(4), .FRAME_BIT(2)
  ) dut_b (
    .clock_25(clk), .reset(rst), .pix_en(en),
    .h_sync(hs_b), .v_sync(vs_b), .display_area(de_b), .X(x_b), .Y(y_b),
    .line_tik(lt_b), .frame_tik(ft_b), .vblank_tik(vt_b), .frame_count(fc_b)
  );

  typedef struct {
    bit hs, vs, de, lt, ft, vt;
    int x, y, fc;
  } obs_t;

  obs_t q_a[$];
  obs_t q_b[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for the p-th enabled pixel since reset, straight from raster arithmetic.
  function automatic obs_t exp_at(longint p, int hd, int hf, int hw, int hb,
                                  int vd, int vf, int vw, int vb, bit hp, bit vp, int fb);
    obs_t   o;
    longint ht   = hd + hf + hw + hb;
    longint vt   = vd + vf + vw + vb;
    longint hc   = p % ht;
    longint line = p / ht;
    longint vc   = line % vt;
    longint fr   = line / vt;
    o.de = (hc < hd) && (vc < vd);
    o.x  = o.de ? int'(hc) : 0;
    o.y  = o.de ? int'(vc) : 0;
    o.hs = (hc >= hd + hf && hc < hd + hf + hw) ? hp : !hp;
    o.vs = (vc >= vd + vf && vc < vd + vf + vw) ? vp : !vp;
    o.lt = (hc == 0);
    o.ft = (hc == 0) && (vc == 0);
    o.vt = (hc == 0) && (vc == vd);
    o.fc = int'(fr % (longint'(1) << fb));
    return o;
  endfunction

  function automatic obs_t reset_obs(bit hp, bit vp);
    obs_t o;
    o.hs = !hp; o.vs = !vp; o.de = 0; o.lt = 0; o.ft = 0; o.vt = 0;
    o.x = 0; o.y = 0; o.fc = 0;
    return o;
  endfunction

  function automatic bit same(obs_t a, obs_t e);
    return a.hs == e.hs && a.vs == e.vs && a.de == e.de && a.lt == e.lt &&
           a.ft == e.ft && a.vt == e.vt && a.x == e.x && a.y == e.y && a.fc == e.fc;
  endfunction

  task automatic check(input string name, input obs_t a, input obs_t e);
    total++;
    if (!same(a, e)) begin
      bad++;
      $display("FAIL %s t=%0t got hs=%0d vs=%0d de=%0d x=%0d y=%0d lt=%0d ft=%0d vt=%0d fc=%0d want hs=%0d vs=%0d de=%0d x=%0d y=%0d lt=%0d ft=%0d vt=%0d fc=%0d",
               name, $time, a.hs, a.vs, a.de, a.x, a.y, a.lt, a.ft, a.vt, a.fc,
               e.hs, e.vs, e.de, e.x, e.y, e.lt, e.ft, e.vt, e.fc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference model: counts enabled pixels since reset and queues the expected outputs.
  longint n_a = 0, n_b = 0;
  bit     known = 0;
  obs_t   cur_a, cur_b;
  always @(posedge clk) begin
    if (rst) begin
      n_a = 0; n_b = 0; known = 1;
      cur_a = reset_obs(1'b0, 1'b0);
      cur_b = reset_obs(1'b1, 1'b1);
    end else if (en) begin
      cur_a = exp_at(n_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8);
      cur_b = exp_at(n_b, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2);
      n_a++; n_b++;
    end else begin
      cur_a.lt = 0; cur_a.ft = 0; cur_a.vt = 0;
      cur_b.lt = 0; cur_b.ft = 0; cur_b.vt = 0;
    end
    if (known) begin
      q_a.push_back(cur_a);
      q_b.push_back(cur_b);
    end
  end

  // Monitor: every falling edge the DUTs present outputs; pop and compare.
  always @(negedge clk) begin
    obs_t e, a;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      a.hs = hs_a; a.vs = vs_a; a.de = de_a; a.lt = lt_a; a.ft = ft_a; a.vt = vt_a;
      a.x = int'(x_a); a.y = int'(y_a); a.fc = int'(fc_a);
      check("dflt", a, e);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      a.hs = hs_b; a.vs = vs_b; a.de = de_b; a.lt = lt_b; a.ft = ft_b; a.vt = vt_b;
      a.x = int'(x_b); a.y = int'(y_b); a.fc = int'(fc_b);
      check("small", a, e);
    end
  end

  // Stimulus: reset, continuous run, alternating and random enable, random and targeted resets.
  initial begin
    int hs_cnt = 0;
    int lt_cnt = 0;
    int ft_cnt = 0;
    int w      = 0;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Observed outputs here are positions 0..2399 of both rasters.
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk);
      if (i < 800 && hs_a == 1'b0) hs_cnt++;
      if (lt_a) lt_cnt++;
      if (ft_b) ft_cnt++;
    end
    check_int("hsync_width_dflt", hs_cnt, 96);
    check_int("line_tiks_dflt", lt_cnt, 3);
    check_int("frame_tiks_small", ft_cnt, 25);

    for (int i = 0; i < 3000; i++) begin
      en = i[0];
      @(negedge clk);
    end
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 4) != 0;
      @(negedge clk);
    end
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom % 300) == 0;
      en  = ($urandom % 2) != 0;
      @(negedge clk);
    end

    // One-clock reset in the middle of a default-raster h_sync pulse.
    rst = 1'b0;
    en  = 1'b1;
    while (hs_a !== 1'b0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check_int("hsync_seen_before_reset", (w < 2000) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (1000) @(negedge clk);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
